// File: rtl/wishbone_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_manager_if
// Description : Wishbone B4 classic bus bundle between the wishbone_manager
//               (master) and the shared SoC bus/slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wishbone_manager_if;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I;
  logic        ACK_I;
  logic        ERR_I;

  modport master (
    output CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O,
    input  DAT_I, ACK_I, ERR_I
  );

  modport slave (
    input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O,
    output DAT_I, ACK_I, ERR_I
  );
endinterface
`default_nettype wire

// File: rtl/wishbone_manager.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_manager
// Description : Turns the CPU request unit's level-held read/write request
//               into one Wishbone B4 classic cycle, returns read data and
//               aborts cycles that never see ACK/ERR via a watchdog counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_manager #(
  parameter int CPU_ADDR_W = 5,
  parameter int TIMEOUT    = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  read_i,
  input  wire logic                  write_i,
  input  wire logic [CPU_ADDR_W-1:0] adr_i,
  input  wire logic [31:0]           cpu_dat_i,
  input  wire logic [3:0]            sel_i,
  output logic [31:0]                cpu_dat_o,
  output logic                       busy_o,
  output logic                       err_o,
  wishbone_manager_if.master         wb
);

  // Watchdog fires when the counter sits at TIMEOUT-1 without a response,
  // giving exactly TIMEOUT cycles of CYC_O before the abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q,   cyc_d;
  logic        stb_q,   stb_d;
  logic        we_q,    we_d;
  logic [31:0] adr_q,   adr_d;
  logic [31:0] dat_q,   dat_d;
  logic [3:0]  sel_q,   sel_d;
  logic [31:0] rdat_q,  rdat_d;
  logic        busy_q,  busy_d;
  logic        err_q,   err_d;
  logic [7:0]  cnt_q,   cnt_d;

  logic [31:0] adr_ext;
  logic        abort;

  // Zero-extend the CPU address onto the 32-bit bus address.
  always_comb begin
    adr_ext                 = '0;
    adr_ext[CPU_ADDR_W-1:0] = adr_i;
  end

  // Next-state and registered-output computation; hold everything by default.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    abort   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Write wins over read when both are requested.
        if (write_i || read_i) begin
          adr_d   = adr_ext;
          sel_d   = sel_i;
          we_d    = write_i;
          if (write_i) begin
            dat_d = cpu_dat_i;
          end
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end

      ST_BUS: begin
        cnt_d = cnt_q + 8'd1;
        // ERR_I outranks ACK_I; a silent slave is treated like ERR_I.
        abort = wb.ERR_I || (!wb.ACK_I && (cnt_q == CNT_LAST));
        if (abort || wb.ACK_I) begin
          if (!abort && !we_q) begin
            rdat_d = wb.DAT_I;
          end
          err_d   = abort;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb.CYC_O  = cyc_q;
  assign wb.STB_O  = stb_q;
  assign wb.WE_O   = we_q;
  assign wb.ADR_O  = adr_q;
  assign wb.DAT_O  = dat_q;
  assign wb.SEL_O  = sel_q;
  assign cpu_dat_o = rdat_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_wishbone_manager
// Description : Directed self-checking bench for wishbone_manager.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wishbone_manager;

  logic        clk;
  logic        rst;
  logic        read_i;
  logic        write_i;
  logic [4:0]  adr_i;
  logic [31:0] cpu_dat_i;
  logic [3:0]  sel_i;
  logic [31:0] cpu_dat_o;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  wishbone_manager_if wb();

  wishbone_manager #(
    .CPU_ADDR_W (5),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .adr_i     (adr_i),
    .cpu_dat_i (cpu_dat_i),
    .sel_i     (sel_i),
    .cpu_dat_o (cpu_dat_o),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .wb        (wb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle 1 time unit before checking/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with random request/bus inputs
    rst        = 1'b0;
    read_i     = 1'($urandom);
    write_i    = 1'($urandom);
    adr_i      = 5'($urandom);
    cpu_dat_i  = $urandom;
    sel_i      = 4'($urandom);
    wb.DAT_I   = $urandom;
    wb.ACK_I   = 1'($urandom);
    wb.ERR_I   = 1'($urandom);
    tick();
    tick();
    chk("rst_cyc",  {31'd0, wb.CYC_O}, 32'd0);
    chk("rst_stb",  {31'd0, wb.STB_O}, 32'd0);
    chk("rst_we",   {31'd0, wb.WE_O},  32'd0);
    chk("rst_adr",  wb.ADR_O,          32'd0);
    chk("rst_dat",  wb.DAT_O,          32'd0);
    chk("rst_sel",  {28'd0, wb.SEL_O}, 32'd0);
    chk("rst_rdat", cpu_dat_o,         32'd0);
    chk("rst_busy", {31'd0, busy_o},   32'd0);
    chk("rst_err",  {31'd0, err_o},    32'd0);

    // Release reset, stay idle 5 cycles
    read_i   = 1'b0;
    write_i  = 1'b0;
    wb.ACK_I = 1'b0;
    wb.ERR_I = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_cyc", {31'd0, wb.CYC_O}, 32'd0);
    end

    // Single read, ACK in third CYC_O cycle
    adr_i  = 5'h0C;
    sel_i  = 4'hF;
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
    chk("rd_cyc",  {31'd0, wb.CYC_O}, 32'd1);
    chk("rd_stb",  {31'd0, wb.STB_O}, 32'd1);
    chk("rd_we",   {31'd0, wb.WE_O},  32'd0);
    chk("rd_adr",  wb.ADR_O,          32'h0000_000C);
    chk("rd_sel",  {28'd0, wb.SEL_O}, 32'hF);
    chk("rd_dato", wb.DAT_O,          32'd0);
    chk("rd_busy1", {31'd0, busy_o},  32'd1);
    tick();
    chk("rd_busy2", {31'd0, busy_o},  32'd1);
    tick();
    chk("rd_busy3", {31'd0, busy_o},  32'd1);
    wb.ACK_I = 1'b1;
    wb.DAT_I = 32'h1234_5678;
    tick();
    wb.ACK_I = 1'b0;
    chk("rd_end_cyc",  {31'd0, wb.CYC_O}, 32'd0);
    chk("rd_end_busy", {31'd0, busy_o},   32'd0);
    chk("rd_data",     cpu_dat_o,         32'h1234_5678);

    // Single write, zero-wait ACK
    adr_i     = 5'h03;
    cpu_dat_i = 32'hCAFE_F00D;
    sel_i     = 4'h3;
    write_i   = 1'b1;
    tick();
    write_i  = 1'b0;
    chk("wr_cyc", {31'd0, wb.CYC_O}, 32'd1);
    chk("wr_we",  {31'd0, wb.WE_O},  32'd1);
    chk("wr_adr", wb.ADR_O,          32'h0000_0003);
    chk("wr_dat", wb.DAT_O,          32'hCAFE_F00D);
    chk("wr_sel", {28'd0, wb.SEL_O}, 32'h3);
    wb.ACK_I = 1'b1;
    wb.DAT_I = 32'h5555_AAAA;
    tick();
    wb.ACK_I = 1'b0;
    chk("wr_end_cyc", {31'd0, wb.CYC_O}, 32'd0);
    chk("wr_end_we",  {31'd0, wb.WE_O},  32'd0);
    chk("wr_rdat",    cpu_dat_o,         32'h1234_5678);

    // Simultaneous read and write: write wins
    adr_i     = 5'h01;
    cpu_dat_i = 32'hAAAA_5555;
    sel_i     = 4'hF;
    read_i    = 1'b1;
    write_i   = 1'b1;
    tick();
    read_i  = 1'b0;
    write_i = 1'b0;
    chk("both_we",  {31'd0, wb.WE_O}, 32'd1);
    chk("both_dat", wb.DAT_O,         32'hAAAA_5555);
    wb.ACK_I = 1'b1;
    tick();
    wb.ACK_I = 1'b0;
    chk("both_end", {31'd0, wb.CYC_O}, 32'd0);
    chk("both_rdat", cpu_dat_o,        32'h1234_5678);

    // Back-to-back reads with read_i held
    adr_i  = 5'h02;
    read_i = 1'b1;
    tick();
    chk("b2b_cyc1", {31'd0, wb.CYC_O}, 32'd1);
    wb.ACK_I = 1'b1;
    wb.DAT_I = 32'h1111_2222;
    tick();
    wb.ACK_I = 1'b0;
    chk("b2b_gap",   {31'd0, wb.CYC_O}, 32'd0);
    chk("b2b_data1", cpu_dat_o,         32'h1111_2222);
    tick();
    chk("b2b_cyc2", {31'd0, wb.CYC_O}, 32'd1);
    read_i   = 1'b0;
    wb.ACK_I = 1'b1;
    wb.DAT_I = 32'h3333_4444;
    tick();
    wb.ACK_I = 1'b0;
    chk("b2b_end",   {31'd0, wb.CYC_O}, 32'd0);
    chk("b2b_data2", cpu_dat_o,         32'h3333_4444);

    // Timeout: no response for 16 cycles
    adr_i  = 5'h04;
    read_i = 1'b1;
    wb.DAT_I = 32'hBAD0_BAD0;
    tick();
    read_i = 1'b0;
    chk("to_cyc0", {31'd0, wb.CYC_O}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("to_cyc_hold", {31'd0, wb.CYC_O}, 32'd1);
      chk("to_err_low",  {31'd0, err_o},    32'd0);
    end
    tick();
    chk("to_cyc_drop", {31'd0, wb.CYC_O}, 32'd0);
    chk("to_err",      {31'd0, err_o},    32'd1);
    chk("to_busy",     {31'd0, busy_o},   32'd0);
    chk("to_rdat",     cpu_dat_o,         32'h3333_4444);
    tick();
    chk("to_err_pulse", {31'd0, err_o},   32'd0);

    // ERR_I together with ACK_I in second cycle
    adr_i  = 5'h05;
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
    chk("er_cyc1", {31'd0, wb.CYC_O}, 32'd1);
    tick();
    chk("er_cyc2", {31'd0, wb.CYC_O}, 32'd1);
    wb.ERR_I = 1'b1;
    wb.ACK_I = 1'b1;
    wb.DAT_I = 32'hDEAD_BEEF;
    tick();
    wb.ERR_I = 1'b0;
    wb.ACK_I = 1'b0;
    chk("er_cyc_drop", {31'd0, wb.CYC_O}, 32'd0);
    chk("er_err",      {31'd0, err_o},    32'd1);
    chk("er_busy",     {31'd0, busy_o},   32'd0);
    chk("er_rdat",     cpu_dat_o,         32'h3333_4444);
    tick();
    chk("er_err_pulse", {31'd0, err_o},   32'd0);

    // Asynchronous reset mid-cycle
    adr_i     = 5'h06;
    cpu_dat_i = 32'h0BAD_CAFE;
    write_i   = 1'b1;
    tick();
    write_i = 1'b0;
    chk("ar_cyc_pre", {31'd0, wb.CYC_O}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_cyc",  {31'd0, wb.CYC_O}, 32'd0);
    chk("ar_stb",  {31'd0, wb.STB_O}, 32'd0);
    chk("ar_busy", {31'd0, busy_o},   32'd0);
    chk("ar_rdat", cpu_dat_o,         32'd0);
    tick();
    rst      = 1'b1;
    wb.ACK_I = 1'b1;
    wb.DAT_I = 32'h7777_7777;
    tick();
    wb.ACK_I = 1'b0;
    chk("late_ack_cyc",  {31'd0, wb.CYC_O}, 32'd0);
    chk("late_ack_err",  {31'd0, err_o},    32'd0);
    chk("late_ack_rdat", cpu_dat_o,         32'd0);

    // Normal operation after reset
    adr_i  = 5'h1F;
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
    chk("post_cyc", {31'd0, wb.CYC_O}, 32'd1);
    chk("post_adr", wb.ADR_O,          32'h0000_001F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
